// File: rtl/adc_scan_sequencer_if.sv
`timescale 1ns/1ps
// ADC bus shared between the scan sequencer and the serial ADC front end:
// channel select going out, conversion strobe and result coming back.
interface adc_scan_sequencer_if #(
    parameter int NCH = 8
);
    logic [$clog2(NCH)-1:0] chan;
    logic                   adc_convst;
    logic [11:0]            adc_result;

    // Sequencer side: drives the channel select, watches strobe and result.
    modport master (
        output chan,
        input  adc_convst,
        input  adc_result
    );

    // ADC side: consumes the channel select, produces strobe and result.
    modport slave (
        input  chan,
        output adc_convst,
        output adc_result
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
`timescale 1ns/1ps
// Round-robin ADC scan sequencer. Walks the enabled channels one per ADC
// frame, tags each returned result with the channel that was programmed
// PIPE frames earlier, and publishes tagged samples as a strobe stream plus
// a per-channel hold bank.
//
// Sample stream semantics: sample_valid is a one-cycle strobe with no ready
// signal; sample_chan/sample_data/scan_done are meaningful only in that
// cycle, and the consumer must take every strobe (at most one per frame).
module adc_scan_sequencer #(
    parameter int NCH  = 8,
    parameter int PIPE = 2
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [NCH-1:0]         chan_en,
    adc_scan_sequencer_if.master   adc,
    output logic                   sample_valid,
    output logic [$clog2(NCH)-1:0] sample_chan,
    output logic [11:0]            sample_data,
    output logic                   scan_done,
    input  logic [$clog2(NCH)-1:0] rd_chan,
    output logic [11:0]            rd_data,
    output logic                   rd_fresh,
    output logic                   state_dbg
);
    localparam int CW = $clog2(NCH);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic            cs_s1, cs_s2, cs_d;
    logic            evt;
    logic [CW-1:0]   chan_q, chan_nxt;
    logic [CW:0]     cand;
    logic [PIPE-1:0] tag_v;
    logic [CW-1:0]   tag_c [PIPE];
    logic [CW-1:0]   top_idx;
    logic            any_en;
    logic            pop_v;
    logic [CW-1:0]   pop_c;
    logic [11:0]     bank [NCH];
    logic [NCH-1:0]  fresh;

    // Two-flop synchronizer for the strobe plus a delayed copy for edge detect.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cs_s1 <= 1'b0;
            cs_s2 <= 1'b0;
            cs_d  <= 1'b0;
        end else begin
            cs_s1 <= adc.adc_convst;
            cs_s2 <= cs_s1;
            cs_d  <= cs_s2;
        end
    end

    // Frame boundary: rising edge of the synchronized strobe.
    assign evt = cs_s2 & ~cs_d;

    // Highest enabled index, used to recognise the sample closing a sweep.
    always_comb begin
        top_idx = '0;
        any_en  = 1'b0;
        for (int j = 0; j < NCH; j++) begin
            if (chan_en[j]) begin
                top_idx = CW'(j);
                any_en  = 1'b1;
            end
        end
    end

    // State register: IDLE/RUN, re-evaluated only at frame boundaries.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the mask seen at this boundary decides the state of the
    // frame that starts here, so the first frame after enabling is tagged.
    always_comb begin
        state_d = state_q;
        if (evt) begin
            state_d = any_en ? RUN : IDLE;
        end
    end

    // Next channel: first enabled index after chan_q, wrapping modulo NCH.
    // Scanning from the far end lets the nearest hit win; offset NCH is
    // chan_q itself, so a lone enabled current channel stays put.
    always_comb begin
        chan_nxt = chan_q;
        cand     = '0;
        for (int i = NCH; i >= 1; i--) begin
            cand = {1'b0, chan_q} + (CW+1)'(i);
            if (cand >= (CW+1)'(NCH)) begin
                cand = cand - (CW+1)'(NCH);
            end
            if (chan_en[cand[CW-1:0]]) begin
                chan_nxt = cand[CW-1:0];
            end
        end
    end

    assign pop_v = tag_v[PIPE-1];
    assign pop_c = tag_c[PIPE-1];

    // Channel select and tag pipeline, both advancing once per frame.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            chan_q <= '0;
            tag_v  <= '0;
            for (int j = 0; j < PIPE; j++) begin
                tag_c[j] <= '0;
            end
        end else if (evt) begin
            for (int j = PIPE - 1; j > 0; j--) begin
                tag_v[j] <= tag_v[j-1];
                tag_c[j] <= tag_c[j-1];
            end
            tag_v[0] <= (state_d == RUN);
            tag_c[0] <= chan_q;
            if (state_d == RUN) begin
                chan_q <= chan_nxt;
            end
        end
    end

    // Sample strobe and hold bank: capture the result for the popped tag.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sample_valid <= 1'b0;
            sample_chan  <= '0;
            sample_data  <= '0;
            scan_done    <= 1'b0;
            fresh        <= '0;
            for (int j = 0; j < NCH; j++) begin
                bank[j] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            scan_done    <= 1'b0;
            if (evt && pop_v) begin
                sample_valid <= 1'b1;
                sample_chan  <= pop_c;
                sample_data  <= adc.adc_result;
                scan_done    <= any_en && (pop_c == top_idx);
                bank[pop_c]  <= adc.adc_result;
                fresh[pop_c] <= 1'b1;
            end
        end
    end

    assign adc.chan  = chan_q;
    assign rd_data   = bank[rd_chan];
    assign rd_fresh  = fresh[rd_chan];
    assign state_dbg = (state_q == RUN);

endmodule

// File: tb/tb_adc_scan_sequencer.sv
`timescale 1ns/1ps
// Directed bench for adc_scan_sequencer: frames are driven one at a time,
// a reference model of the channel walk and tag pipeline pushes expected
// samples into exp_q, and a negedge monitor pops them as samples appear.
module tb_adc_scan_sequencer;
    localparam int NCH  = 8;
    localparam int PIPE = 2;
    localparam int W    = 16;

    logic        CLOCK_50;
    logic        reset;
    logic [7:0]  chan_en;
    logic        sample_valid;
    logic [2:0]  sample_chan;
    logic [11:0] sample_data;
    logic        scan_done;
    logic [2:0]  rd_chan;
    logic [11:0] rd_data;
    logic        rd_fresh;
    logic        state_dbg;

    adc_scan_sequencer_if #(.NCH(NCH)) adc_bus ();

    adc_scan_sequencer #(.NCH(NCH), .PIPE(PIPE)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .chan_en      (chan_en),
        .adc          (adc_bus),
        .sample_valid (sample_valid),
        .sample_chan  (sample_chan),
        .sample_data  (sample_data),
        .scan_done    (scan_done),
        .rd_chan      (rd_chan),
        .rd_data      (rd_data),
        .rd_fresh     (rd_fresh),
        .state_dbg    (state_dbg)
    );

    // Clock / reset block
    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Scoreboard state: {scan_done, chan, data}
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_w;
    int checks = 0;
    int errors = 0;
    int n_samp = 0;
    int n_exp  = 0;
    int n_done = 0;
    int mon_cnt[NCH] = '{default: 0};

    // Reference model
    int          m_chan;
    logic        m_tv[PIPE];
    int          m_tc[PIPE];
    logic [11:0] m_bank[NCH];
    logic        m_fresh[NCH];

    int t2_seq[6] = '{2, 5, 7, 0, 2, 5};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int top_of(input logic [7:0] en);
        int t = 0;
        for (int i = 0; i < NCH; i++) if (en[i]) t = i;
        return t;
    endfunction

    task automatic model_reset();
        m_chan = 0;
        for (int i = 0; i < PIPE; i++) begin
            m_tv[i] = 1'b0;
            m_tc[i] = 0;
        end
        for (int i = 0; i < NCH; i++) begin
            m_bank[i]  = 12'h000;
            m_fresh[i] = 1'b0;
        end
    endtask

    task automatic model_frame(input logic [7:0] en, input logic [11:0] res);
        logic sd;
        if (m_tv[PIPE-1]) begin
            sd = (en != 8'h00) && (m_tc[PIPE-1] == top_of(en));
            exp_q.push_back({sd, 3'(m_tc[PIPE-1]), res});
            n_exp++;
            m_bank[m_tc[PIPE-1]]  = res;
            m_fresh[m_tc[PIPE-1]] = 1'b1;
        end
        for (int j = PIPE - 1; j > 0; j--) begin
            m_tv[j] = m_tv[j-1];
            m_tc[j] = m_tc[j-1];
        end
        m_tv[0] = (en != 8'h00);
        m_tc[0] = m_chan;
        if (en != 8'h00) begin
            for (int i = 1; i <= NCH; i++) begin
                if (en[(m_chan + i) % NCH]) begin
                    m_chan = (m_chan + i) % NCH;
                    break;
                end
            end
        end
    endtask

    // Driver: one ADC frame with the strobe edge at a random clock phase.
    task automatic frame(input logic [7:0] en, input logic [11:0] res);
        chan_en            = en;
        adc_bus.adc_result = res;
        model_frame(en, res);
        #($urandom_range(1, 19));
        adc_bus.adc_convst = 1'b1;
        repeat (5) @(posedge CLOCK_50);
        #($urandom_range(1, 19));
        adc_bus.adc_convst = 1'b0;
        repeat (4) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("frame_sample_count", n_samp, n_exp);
        chk("frame_chan", 32'(adc_bus.chan), m_chan);
    endtask

    task automatic check_bank();
        for (int i = 0; i < NCH; i++) begin
            rd_chan = 3'(i);
            #1;
            chk("bank_data", rd_data, m_bank[i]);
            chk("bank_fresh", rd_fresh, m_fresh[i]);
        end
    endtask

    // Monitor: pop and compare on every sample strobe.
    always @(negedge CLOCK_50) begin
        if (sample_valid === 1'b1) begin
            n_samp++;
            mon_cnt[sample_chan]++;
            if (scan_done === 1'b1) n_done++;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_sample observed chan=%0d data=%0h expected none", sample_chan, sample_data);
            end
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                checks++;
                assert ({scan_done, sample_chan, sample_data} === exp_w) else begin
                    errors++;
                    $error("FAIL sample observed=%0h expected=%0h", {scan_done, sample_chan, sample_data}, exp_w);
                end
            end
        end else if (scan_done !== 1'b0) begin
            checks++;
            assert (scan_done === 1'b0) else begin
                errors++;
                $error("FAIL scan_done_alone observed=%0b expected=0", scan_done);
            end
        end
    end

    initial begin
        int base;
        int c1;
        int c7;
        int d0;
        reset              = 1'b1;
        chan_en            = 8'h00;
        rd_chan            = 3'd0;
        adc_bus.adc_convst = 1'b0;
        adc_bus.adc_result = 12'h000;
        model_reset();

        // Reset state
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        chk("rst_valid", sample_valid, 0);
        chk("rst_chan_out", sample_chan, 0);
        chk("rst_data", sample_data, 0);
        chk("rst_done", scan_done, 0);
        chk("rst_chan", adc_bus.chan, 0);
        chk("rst_state", state_dbg, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_fresh", rd_fresh, 0);
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        @(negedge CLOCK_50);

        // Single channel
        for (int n = 0; n < 6; n++) begin
            frame(8'h01, 12'h100 + 12'(n));
            chk("t1_chan", adc_bus.chan, 0);
            if (n == 1) chk("t1_no_early_sample", n_samp, 0);
            if (n == 2) begin
                chk("t1_first_count", n_samp, 1);
                chk("t1_first_chan", sample_chan, 0);
                chk("t1_first_data", sample_data, 12'h102);
            end
        end
        chk("t1_done_each", n_done, 4);
        chk("t1_state", state_dbg, 1);

        // Round-robin with wrap
        d0 = n_done;
        c7 = mon_cnt[7];
        for (int k = 0; k < 6; k++) begin
            frame(8'hA5, 12'h800 | 12'($urandom_range(0, 2047)));
            chk("t2_chan_seq", adc_bus.chan, t2_seq[k]);
        end
        chk("t2_done_count", n_done - d0, 1);
        chk("t2_ch7_count", mon_cnt[7] - c7, 1);

        // Disable in flight
        c1 = mon_cnt[1];
        frame(8'h03, 12'($urandom_range(0, 4095)));
        frame(8'h03, 12'($urandom_range(0, 4095)));
        chk("t3_chan_is_1", adc_bus.chan, 1);
        for (int k = 0; k < 5; k++) frame(8'h01, 12'($urandom_range(0, 4095)));
        chk("t3_ch1_once", mon_cnt[1] - c1, 1);
        chk("t3_last_chan", sample_chan, 0);
        rd_chan = 3'd1;
        #1;
        chk("t3_rd_fresh1", rd_fresh, 1);
        check_bank();

        // All channels disabled, then re-enable
        for (int k = 0; k < 3; k++) frame(8'h10, 12'($urandom_range(0, 4095)));
        chk("t4_chan_4", adc_bus.chan, 4);
        frame(8'h00, 12'h111);
        frame(8'h00, 12'h222);
        base = n_samp;
        frame(8'h00, 12'h333);
        frame(8'h00, 12'h444);
        chk("t4_idle_no_sample", n_samp, base);
        chk("t4_idle_chan_hold", adc_bus.chan, 4);
        chk("t4_idle_state", state_dbg, 0);
        frame(8'h10, 12'h555);
        frame(8'h10, 12'h666);
        chk("t4_not_yet", n_samp, base);
        frame(8'h10, 12'h777);
        chk("t4_first_after", n_samp, base + 1);
        chk("t4_first_chan", sample_chan, 4);
        chk("t4_first_data", sample_data, 12'h777);

        // Reset mid-run with tags in flight
        for (int k = 0; k < 3; k++) frame(8'hFF, 12'h800 | 12'($urandom_range(0, 2047)));
        chk("t5_chan_pre", adc_bus.chan, 7);
        chk("t5_queue_empty", exp_q.size(), 0);
        #3 reset = 1'b1;
        #1;
        chk("t5_rst_valid", sample_valid, 0);
        chk("t5_rst_chan_out", sample_chan, 0);
        chk("t5_rst_data", sample_data, 0);
        chk("t5_rst_chan", adc_bus.chan, 0);
        chk("t5_rst_state", state_dbg, 0);
        model_reset();
        for (int i = 0; i < NCH; i++) begin
            rd_chan = 3'(i);
            #1;
            chk("t5_rd_data_zero", rd_data, 0);
            chk("t5_rd_fresh_zero", rd_fresh, 0);
        end
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        @(negedge CLOCK_50);
        base = n_samp;
        frame(8'hFF, 12'hABC);
        frame(8'hFF, 12'hBCD);
        chk("t5_no_stale", n_samp, base);
        frame(8'hFF, 12'hCDE);
        chk("t5_first_after_rst", n_samp, base + 1);
        chk("t5_first_chan", sample_chan, 0);
        chk("t5_first_data", sample_data, 12'hCDE);

        // Random phases and masks
        for (int k = 0; k < 10; k++) begin
            frame(8'($urandom_range(1, 255)), 12'($urandom_range(0, 4095)));
        end
        check_bank();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Round-robin scheduler that shares the single 8-channel serial ADC interface between the joystick and potentiometer inputs. It drives the interface's `chan` select and watches the interface's `ADC_CONVST` strobe to mark frame boundaries. Each returned `result` is tagged with the channel it belongs to, accounting for the ADC's pipelined channel programming. Tagged samples are published as a one-cycle stream plus a per-channel hold bank for the servo-angle logic and the 7-segment display.

## Interface
- `NCH`, 8: number of ADC channels; `chan` width is clog2(NCH).
- `PIPE`, 2: frame boundaries between a channel being presented on `chan` and its result being captured; legal range 1..4.
- `CLOCK_50` in 1: system clock, 50 MHz; the only clock.
- `reset` in 1: asynchronous, active-high; clears all state immediately, released synchronously by the board reset logic.
- `chan_en` in NCH: channel enable mask; sampled at each frame boundary.
- `adc_convst` in 1: `ADC_CONVST` from the ADC interface; asynchronous to `CLOCK_50`, synchronized internally with 2 flops.
- `adc_result` in 12: `result` from the ADC interface; source holds it stable from the end of one frame until after the next `adc_convst` rising edge.
- `chan` out 3: channel select to the ADC interface.
- `sample_valid` out 1: one-cycle pulse, a tagged sample is available.
- `sample_chan` out 3: channel of the current sample.
- `sample_data` out 12: value of the current sample.
- `scan_done` out 1: one-cycle pulse coincident with the `sample_valid` that completes a sweep.
- `rd_chan` in 3: hold-bank read address.
- `rd_data` out 12: combinational read of bank[`rd_chan`].
- `rd_fresh` out 1: bank[`rd_chan`] has been written since reset.

## Operation
- **Frame boundary (event E):** cycle where the synchronized `adc_convst` is 1 and its delayed copy is 0.
- **States:**
  - IDLE (`chan_en` == 0): `chan` holds its value; tag 0 is loaded invalid.
  - RUN (`chan_en` != 0).
  - The state is re-evaluated at each E.
- **Tag pipeline:** PIPE entries of {valid, chan}. At E:
  - entry PIPE-1 is popped; if it is valid, `adc_result` is captured with that tag;
  - entries shift up by one;
  - entry 0 is loaded with {state==RUN, current `chan`}.
- **Channel advance at E (RUN):** `chan` becomes the first enabled index searching `chan`+1, `chan`+2, … with modulo NCH wrap.
  - If only the current channel is enabled, `chan` stays.
  - IDLE→RUN: the search starts from `chan`+1.
- **Sample delivery:** a popped valid tag raises `sample_valid` with `sample_chan`/`sample_data` and writes bank[tag] plus its fresh bit.
- **Disabled channels:** disabling a channel does not cancel its in-flight tags; those samples are still delivered.
- **`scan_done`:** asserted when the delivered tag equals the highest index set in `chan_en` as sampled at that E.
- **`adc_result`:** used only at E; all other values are ignored.
- **Reset values:**
  - `chan`=0, all tags invalid, state IDLE;
  - `sample_valid`=0, `sample_chan`=0, `sample_data`=0, `scan_done`=0;
  - bank all 0, fresh bits all 0, so `rd_data`=0 and `rd_fresh`=0.
- **Reset mid-operation:** everything above clears. In-flight conversions are discarded, and the first PIPE frames after reset deliver nothing.

## Timing
- `adc_convst` edge to E: 2–3 `CLOCK_50` cycles (synchronizer plus edge detect).
- All of the following are registered at E+1:
  - `sample_valid`, `sample_chan`, `sample_data`, `scan_done` (1 cycle wide);
  - the `chan` update;
  - the bank write.
- `rd_data` and `rd_fresh` reflect a bank write from E+1 onward.
- End-to-end latency: a channel presented during frame k is delivered at frame boundary k+PIPE.
- At most one sample per frame; no back-pressure (consumers must accept every pulse).
- A `chan_en` change takes effect at the next E only.
- An `adc_convst` pulse shorter than 2 `CLOCK_50` periods is not guaranteed to register. The ADC interface's pulse is 1 `adc_clk` period (640 ns), which is sufficient.

## Test plan
- **Single channel:** reset, `chan_en`=8'h01, 6 `adc_convst` pulses with `adc_result`=12'h100+n.
  - `chan` stays 0.
  - First `sample_valid` on pulse 3 (PIPE=2), carrying chan 0 and 12'h102.
  - `scan_done` on every sample.
- **Round-robin with wrap:** `chan_en`=8'b1010_0101.
  - `chan` sequence 0,2,5,7,0,2.
  - `sample_chan` follows the same sequence two frames later.
  - `scan_done` only with chan 7.
- **Disable in flight:** `chan_en` goes 8'h03→8'h01 just after a frame where `chan`=1.
  - Chan 1 is still delivered once.
  - Afterwards only chan 0 is delivered.
  - `rd_fresh`=1 for `rd_chan`=1.
- **All channels disabled:** `chan_en`=0 for 4 frames.
  - No `sample_valid`; `chan` holds.
  - On re-enable with 8'h10, the first sample (chan 4) arrives PIPE frames later.
- **Reset mid-run:** `reset` pulsed between frames with tags in flight.
  - Outputs are 0 immediately.
  - No stale sample is delivered.
  - Bank `rd_data`=0 and `rd_fresh`=0 for all channels.
- **Synchronizer:** `adc_convst` edges placed at random phases relative to `CLOCK_50`.
  - Exactly one E per pulse.
  - `sample_data` matches the `adc_result` held stable across the edge.
